// File: rtl/user_proj_solar_scan.sv
`default_nettype none
// ============================================================================
// Module      : user_proj_solar_scan
// Description : Multi-panel solar monitor. Steps an external analog mux over
//               NUM_CH panels, samples a shared ADC bus, averages each panel
//               over 2^AVG_LOG2 full scans and raises a debounced per-panel
//               fault when the average stays below THRESH.
// Revision    : 1.0  initial release
// ============================================================================
module user_proj_solar_scan #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 10,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 8,
  parameter int THRESH     = 300,
  parameter int FAULT_CNT  = 3,
  localparam int CSW       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
  localparam int OUT_W     = CSW + 3 + NUM_CH
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [DATA_W:0]   io_in,
  output logic [OUT_W-1:0]  io_out,
  output logic [OUT_W-1:0]  io_oeb
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SCAN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int DBC_W  = $clog2(FAULT_CNT + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CSW-1:0]    CH_LAST     = CSW'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] THRESH_C    = DATA_W'(THRESH);
  localparam logic [DBC_W-1:0]  DBC_MAX     = DBC_W'(FAULT_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } state_e;

  state_e              state_q;
  logic [CSW-1:0]      ch_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [SET_W-1:0]    settle_q;
  logic                strobe_q;
  logic                hb_q;
  logic                any_q;
  logic [OUT_W-1:0]    oeb_q;

  logic                en_w;
  logic [DATA_W-1:0]   adc_w;
  logic                sample_w;
  logic                eval_w;
  logic                abort_w;
  logic [NUM_CH-1:0]   fault_w;
  logic [NUM_CH-1:0]   fault_nxt_w;

  assign en_w     = io_in[DATA_W];
  assign adc_w    = io_in[DATA_W-1:0];
  // A sample only counts if the scan is still enabled in that cycle.
  assign sample_w = (state_q == SAMPLE) && en_w;
  // EVAL completes even when enable drops in the same cycle.
  assign eval_w   = (state_q == EVAL);
  // Dropping enable mid-window discards the partial accumulation.
  assign abort_w  = (state_q != IDLE) && !en_w;

  // Per-panel accumulator, debounce counter and fault flag.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0]  acc_q;
    logic [DBC_W-1:0]  dbc_q;
    logic [DBC_W-1:0]  dbc_d;
    logic              fault_q;
    logic              fault_d;
    logic [DATA_W-1:0] avg_w;

    // Truncating average: drop the AVG_LOG2 fraction bits.
    assign avg_w = acc_q[ACC_W-1:AVG_LOG2];

    // Debounce update applied at EVAL: saturate on low, clear on healthy.
    always_comb begin
      dbc_d   = dbc_q;
      fault_d = fault_q;
      if (avg_w < THRESH_C) begin
        if (dbc_q != DBC_MAX) begin
          dbc_d = dbc_q + DBC_W'(1);
        end
        if (dbc_d == DBC_MAX) begin
          fault_d = 1'b1;
        end
      end else begin
        dbc_d   = '0;
        fault_d = 1'b0;
      end
    end

    // Accumulate this panel's sample; clear at window end or on abort.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        acc_q   <= '0;
        dbc_q   <= '0;
        fault_q <= 1'b0;
      end else if (eval_w) begin
        acc_q   <= '0;
        dbc_q   <= dbc_d;
        fault_q <= fault_d;
      end else if (abort_w) begin
        acc_q   <= '0;
      end else if (sample_w && (ch_q == CSW'(i))) begin
        acc_q   <= acc_q + ACC_W'(adc_w);
      end
    end

    assign fault_w[i]     = fault_q;
    assign fault_nxt_w[i] = fault_d;
  end

  // Scan sequencer with registered mux select, strobe, heartbeat and summary.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      scan_q   <= '0;
      settle_q <= '0;
      strobe_q <= 1'b0;
      hb_q     <= 1'b0;
      any_q    <= 1'b0;
      oeb_q    <= '1;
    end else begin
      oeb_q    <= '0;
      strobe_q <= 1'b0;
      if (!en_w) begin
        state_q  <= IDLE;
        ch_q     <= '0;
        scan_q   <= '0;
        settle_q <= '0;
        if (state_q == EVAL) begin
          hb_q  <= ~hb_q;
          any_q <= |fault_nxt_w;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= SETTLE;
            settle_q <= '0;
            ch_q     <= '0;
          end
          SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              state_q  <= SAMPLE;
              strobe_q <= 1'b1;
            end else begin
              settle_q <= settle_q + SET_W'(1);
            end
          end
          SAMPLE: begin
            settle_q <= '0;
            if (ch_q != CH_LAST) begin
              ch_q    <= ch_q + CSW'(1);
              state_q <= SETTLE;
            end else begin
              ch_q <= '0;
              if (scan_q == SCAN_LAST) begin
                scan_q  <= '0;
                state_q <= EVAL;
              end else begin
                scan_q  <= scan_q + SCAN_W'(1);
                state_q <= SETTLE;
              end
            end
          end
          EVAL: begin
            hb_q     <= ~hb_q;
            any_q    <= |fault_nxt_w;
            state_q  <= SETTLE;
            settle_q <= '0;
            ch_q     <= '0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign io_out = {any_q, fault_w, hb_q, strobe_q, ch_q};
  assign io_oeb = oeb_q;

endmodule
`default_nettype wire
